// File: rtl/vedic_mul6_seq.sv
// Sequential 6x6 unsigned multiplier that reuses one 3x3 Vedic core over four partial-product steps.
// Optional zero-slice step skipping is enabled by defining VEDIC_MUL6_SEQ_ZSKIP_EN.

module vedic3bit (
   input  logic [2:0] x,
   input  logic [2:0] y,
   output logic [5:0] p
);

   logic [2:0] c1_s, c2_s, c3_s, c4_s;

   // Vertically-and-crosswise column sums with ripple of column carries
   always_comb begin
      c1_s = {2'b00, x[1] & y[0]} + {2'b00, x[0] & y[1]};
      c2_s = {2'b00, x[2] & y[0]} + {2'b00, x[1] & y[1]} + {2'b00, x[0] & y[2]}
           + {2'b00, c1_s[1]};
      c3_s = {2'b00, x[2] & y[1]} + {2'b00, x[1] & y[2]} + {1'b0, c2_s[2:1]};
      c4_s = {2'b00, x[2] & y[2]} + {1'b0, c3_s[2:1]};
      p    = {c4_s[1:0], c3_s[0], c2_s[0], c1_s[0], x[0] & y[0]};
   end

endmodule

module vedic_mul6_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  a,
   input  logic [5:0]  b,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [11:0] product
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  a_q, a_d, b_q, b_d;
   logic [11:0] acc_q, acc_d;
   logic [1:0]  step_q, step_d;
   logic [11:0] product_q, product_d;
   logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d;

   logic [2:0]  xs_s, ys_s;
   logic [5:0]  pp_s;
   logic [11:0] pp_ext_s, pp_sh_s, sum_s;
   logic        last_s;

`ifdef VEDIC_MUL6_SEQ_ZSKIP_EN
   logic [2:0]  nxt_s;

   function automatic logic step_live(input logic [5:0] av, input logic [5:0] bv,
                                      input logic [1:0] s);
      logic [2:0] xv, yv;
      case (s)
         2'd0:    begin xv = av[2:0]; yv = bv[2:0]; end
         2'd1:    begin xv = av[5:3]; yv = bv[2:0]; end
         2'd2:    begin xv = av[2:0]; yv = bv[5:3]; end
         default: begin xv = av[5:3]; yv = bv[5:3]; end
      endcase
      return (xv != 3'd0) && (yv != 3'd0);
   endfunction

   // Returns {none_left, index} of the first live step at or after 'from'
   function automatic logic [2:0] next_live(input logic [5:0] av, input logic [5:0] bv,
                                            input logic [2:0] from);
      logic       found;
      logic [1:0] idx;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!found && (3'(i) >= from) && step_live(av, bv, 2'(i))) begin
            found = 1'b1;
            idx   = 2'(i);
         end
      end
      return {~found, idx};
   endfunction
`endif

   // Select operand slices and shift for the current step
   always_comb begin
      case (step_q)
         2'd0:    begin xs_s = a_q[2:0]; ys_s = b_q[2:0]; end
         2'd1:    begin xs_s = a_q[5:3]; ys_s = b_q[2:0]; end
         2'd2:    begin xs_s = a_q[2:0]; ys_s = b_q[5:3]; end
         default: begin xs_s = a_q[5:3]; ys_s = b_q[5:3]; end
      endcase
      pp_ext_s = {6'b000000, pp_s};
      case (step_q)
         2'd0:    pp_sh_s = pp_ext_s;
         2'd1,
         2'd2:    pp_sh_s = pp_ext_s << 3;
         default: pp_sh_s = pp_ext_s << 6;
      endcase
      sum_s = acc_q + pp_sh_s;
   end

   vedic3bit u_core (
      .x (xs_s),
      .y (ys_s),
      .p (pp_s)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      step_d    = step_q;
      product_d = product_q;
      last_s    = 1'b0;
`ifdef VEDIC_MUL6_SEQ_ZSKIP_EN
      nxt_s     = 3'd0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d   = a;
               b_d   = b;
               acc_d = 12'd0;
`ifdef VEDIC_MUL6_SEQ_ZSKIP_EN
               nxt_s = next_live(a, b, 3'd0);
               if (nxt_s[2]) begin
                  state_d   = ST_DONE;
                  step_d    = 2'd0;
                  product_d = 12'd0;
               end else begin
                  state_d = ST_MUL;
                  step_d  = nxt_s[1:0];
               end
`else
               state_d = ST_MUL;
               step_d  = 2'd0;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            acc_d = sum_s;
`ifdef VEDIC_MUL6_SEQ_ZSKIP_EN
            nxt_s  = next_live(a_q, b_q, {1'b0, step_q} + 3'd1);
            last_s = nxt_s[2];
            step_d = last_s ? 2'd0 : nxt_s[1:0];
`else
            last_s = (step_q == 2'd3);
            step_d = step_q + 2'd1;
`endif
            if (last_s) begin
               state_d   = ST_DONE;
               product_d = sum_s;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d == ST_MUL) || (state_d == ST_DONE);
      done_d  = (state_d == ST_DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= 6'd0;
         b_q       <= 6'd0;
         acc_q     <= 12'd0;
         step_q    <= 2'd0;
         product_q <= 12'd0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         step_q    <= step_d;
         product_q <= product_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_vedic_mul6_seq.sv
// Scoreboard bench for vedic_mul6_seq: directed operands, expected product and latency queued at issue.
module tb_vedic_mul6_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  a, b;
   logic        ready, busy, done;
   logic [11:0] product;

   typedef struct { int prod; int lat; } exp_t;
   exp_t sb[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int done_cnt = 0;
   int last_prod = 0;

   vedic_mul6_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passes++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
   endtask

   // Cycle counter and accept timestamp
   always @(posedge clk) begin
      if (rst_n && start && ready) acc_cyc <= cyc;
      cyc <= cyc + 1;
   end

   // Monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("product", int'(product), e.prod);
            chk("latency", cyc - acc_cyc, e.lat);
         end
      end
   end

   task automatic issue(input logic [5:0] av, input logic [5:0] bv,
                        input int ep, input int lat_def, input int lat_z);
      int n;
      exp_t e;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_issue", int'(ready), 1);
      e.prod = ep;
`ifdef VEDIC_MUL6_SEQ_ZSKIP_EN
      e.lat = lat_z;
`else
      e.lat = lat_def;
`endif
      a = av;
      b = bv;
      start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("ready_low_after_accept", int'(ready), 0);
      chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_done(input int ep);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            chk("product_held", int'(product), last_prod);
            chk("ready_low_while_busy", int'(ready), 0);
            @(negedge clk);
         end
      end
      chk("done_seen", int'(seen), 1);
      last_prod = ep;
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("ready_after_done", int'(ready), 1);
   endtask

   task automatic run(input logic [5:0] av, input logic [5:0] bv,
                      input int ep, input int lat_def, input int lat_z);
      issue(av, bv, ep, lat_def, lat_z);
      wait_done(ep);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst_n = 1'b0;
      start = 1'b0;
      a = 6'd0;
      b = 6'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_product", int'(product), 0);
      rst_n = 1'b1;

      run(6'd63, 6'd63, 3969, 5, 5);
      run(6'd42, 6'd21, 882, 5, 5);
      run(6'd5, 6'd6, 30, 5, 2);
      run(6'd0, 6'd37, 0, 5, 1);
      run(6'd9, 6'd8, 72, 5, 3);
      run(6'd63, 6'd1, 63, 5, 3);
      run(6'd36, 6'd36, 1296, 5, 5);

      // Operand changes and start pulse while busy must not disturb the result
      dc = done_cnt;
      issue(6'd7, 6'd7, 49, 5, 2);
      a = 6'd63;
      b = 6'd63;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(49);
      repeat (8) @(negedge clk);
      chk("single_done", done_cnt - dc, 1);
      chk("idle_after_ignore", int'(busy), 0);

      // Abort during step S2 with an asynchronous reset
      dc = done_cnt;
      issue(6'd63, 6'd63, 3969, 5, 5);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", int'(ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_product", int'(product), 0);
      sb.delete();
      last_prod = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      run(6'd3, 6'd3, 9, 5, 2);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vedic_mul6_seq.md
VEDIC_MUL6_SEQ -- requirements
Module: vedic_mul6_seq

Interface
REQ-001 Parameters: none; widths fixed at 6-bit operands, 12-bit product.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to multiply a by b; sampled only while ready=1.
REQ-005 a  input  6  multiplicand, unsigned; sampled on accepting edge.
REQ-006 b  input  6  multiplier, unsigned; sampled on accepting edge.
REQ-007 ready  output  1  high in IDLE only; start accepted when start=1 and ready=1.
REQ-008 busy  output  1  high in MUL and DONE states.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 product  output  12  last completed result; held until next completion.

Function
REQ-011 Block SHALL contain exactly one vedic3bit instance (3-bit x 3-bit -> 6-bit) and reuse it for all partial products.
REQ-012 Slices: aL=a[2:0], aH=a[5:3], bL=b[2:0], bH=b[5:3], taken from registered operand copies.
REQ-013 Steps: S0 aL*bL <<0; S1 aH*bL <<3; S2 aL*bH <<3; S3 aH*bH <<6; executed in this order, one step per clock.
REQ-014 Accumulator 12 bits, cleared on acceptance; each step adds its shifted partial product; no overflow possible (max 63*63=3969).
REQ-015 FSM states: IDLE, MUL, DONE.
REQ-016 IDLE -> MUL on accept (start=1); operands latched, accumulator cleared, step counter set to first step.
REQ-017 MUL: one step accumulated per edge; after last step's accumulate, product <= final sum and state -> DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-019 Latency: with k steps executed, done is high during cycle k+1 after the accepting edge (k=4 without macro: done in 5th cycle).
REQ-020 start while busy=1 SHALL be ignored; no queuing; a/b changes while busy SHALL NOT affect the result.
REQ-021 start in DONE cycle ignored (ready=0); earliest re-accept is the cycle after done.
REQ-022 product SHALL hold previous result throughout MUL; it changes only on the edge entering DONE.
REQ-023 Back-to-back: start held high continuously yields one accept per k+2 cycles.

Reset
REQ-024 rst_n=0 forces immediately, regardless of clk: state IDLE, ready=1, busy=0, done=0, product=0, accumulator=0, operand registers=0, step counter=0.
REQ-025 Reset mid-operation SHALL abort it; no done pulse for the aborted operation; product reads 0.
REQ-026 First accept possible on first rising edge with rst_n=1 and start=1.

Configuration
REQ-027 Macro VEDIC_MUL6_SEQ_ZSKIP_EN.
REQ-028 Defined: any step whose 3-bit operand slices include a zero slice SHALL be skipped (no cycle spent); next non-skipped step chosen in order; if all four skip (a=0 or b=0), MUL is bypassed: IDLE -> DONE directly, product <= 0, done in cycle 1 after accept (k=0).
REQ-029 Undefined: all four steps always executed, k=4; results identical either way.

Verification
REQ-030 Reset then a=63, b=63, start 1 cycle -> done in 5th cycle after accept, product=3969 (12'hF81), ready low 5 cycles.
REQ-031 a=42, b=21 -> product=882; with ZSKIP_EN all slices nonzero, latency still 5.
REQ-032 a=5, b=6 -> product=30; without macro done in cycle 5; with ZSKIP_EN only S0 runs, done in cycle 2.
REQ-033 a=0, b=37 -> product=0; with ZSKIP_EN done in cycle 1; without, cycle 5; previous product held until that edge.
REQ-034 Accept a=7,b=7, change a/b and pulse start during MUL -> product=49, no second done, single accept.
REQ-035 Accept a=63,b=63, assert rst_n=0 during step S2 -> outputs reset values immediately, no done; after release, a=3,b=3 -> product=9.
